usb_buffer_ctrl: RTL and testbench

//  Controller/arbiter for the 64-byte endpoint data buffer in the USB full-speed endpoint.

---
 rtl/usb_pkg.sv | 13 +
 rtl/usb_buffer_mem.sv | 21 ++
 rtl/usb_buffer_ctrl.sv | 101 ++++++++++
 tb/tb_usb_buffer_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB full-speed endpoint buffer.
package usb_pkg;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_USB,
    SRC_HOST
  } buf_src_e;
endpackage

// File: rtl/usb_buffer_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module usb_buffer_mem
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_buffer_ctrl.sv
// Endpoint buffer controller: arbitrates USB vs host access to the shared buffer,
// owns pointers and occupancy, and flags dropped requests.
module usb_buffer_ctrl
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              rx_push,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              host_push,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              tx_pop,
  input  logic              host_pop,
  output logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_wait,
  output logic [CNT_W-1:0]  occupancy,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  buf_src_e          wr_src;
  buf_src_e          rd_src;
  logic              wr_ok;
  logic              rd_ok;
  logic              mem_we;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_rdata;

  assign empty = (occupancy == '0);
  assign full  = (occupancy == CNT_W'(DEPTH));

  // Losing host request is told to hold; meaningless while flushing or in reset.
  assign host_wait = n_rst & ~flush & ((host_push & rx_push) | (host_pop & tx_pop));

  // Fixed-priority arbitration: USB side always wins; a full buffer still takes a
  // write when a read frees a slot in the same cycle.
  always_comb begin
    wr_src  = SRC_NONE;
    rd_src  = SRC_NONE;
    wr_data = rx_data;
    if (rx_push) begin
      wr_src = SRC_USB;
    end else if (host_push) begin
      wr_src  = SRC_HOST;
      wr_data = host_wdata;
    end
    if (tx_pop)        rd_src = SRC_USB;
    else if (host_pop) rd_src = SRC_HOST;
    rd_ok  = (rd_src != SRC_NONE) && !empty;
    wr_ok  = (wr_src != SRC_NONE) && (!full || rd_ok);
    mem_we = wr_ok && !flush && n_rst;
  end

  usb_buffer_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      occupancy  <= '0;
      tx_data    <= '0;
      host_rdata <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ADDR_W'(1);
      if (rd_ok) begin
        rptr <= rptr + ADDR_W'(1);
        if (rd_src == SRC_USB) tx_data    <= mem_rdata;
        else                   host_rdata <= mem_rdata;
      end
      case ({wr_ok, rd_ok})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      overflow  <= (wr_src != SRC_NONE) && !wr_ok;
      underflow <= (rd_src != SRC_NONE) && !rd_ok;
    end
  end

endmodule

// File: tb/tb_usb_buffer_ctrl.sv
// Scoreboard bench for usb_buffer_ctrl: a reference FIFO predicts read data,
// occupancy and error pulses for every cycle of directed and random traffic.
module tb_usb_buffer_ctrl;
  logic       clk = 1'b0;
  logic       n_rst, flush, rx_push, host_push, tx_pop, host_pop;
  logic [7:0] rx_data, host_wdata, tx_data, host_rdata;
  logic       host_wait, empty, full, overflow, underflow;
  logic [6:0] occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_host[$];
  logic [7:0] last_tx   = 8'h00;
  logic [7:0] last_host = 8'h00;

  always #5 clk = ~clk;

  usb_buffer_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .flush      (flush),
    .rx_push    (rx_push),
    .rx_data    (rx_data),
    .host_push  (host_push),
    .host_wdata (host_wdata),
    .tx_pop     (tx_pop),
    .host_pop   (host_pop),
    .tx_data    (tx_data),
    .host_rdata (host_rdata),
    .host_wait  (host_wait),
    .occupancy  (occupancy),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle of stimulus; predicts the outcome and scores the DUT.
  task automatic cyc(input logic rp, input logic [7:0] rd, input logic hp, input logic [7:0] hd,
                     input logic tp, input logic hpop, input logic fl);
    logic wr, rdq, rd_ok, wr_ok, e_ovf, e_unf;
    logic [7:0] v;
    rx_push = rp; rx_data = rd; host_push = hp; host_wdata = hd;
    tx_pop = tp; host_pop = hpop; flush = fl;
    #1;
    check("host_wait", 32'(host_wait), 32'(!fl && ((hp && rp) || (hpop && tp))));
    e_ovf = 1'b0;
    e_unf = 1'b0;
    if (fl) begin
      model.delete();
    end else begin
      wr    = rp | hp;
      rdq   = tp | hpop;
      rd_ok = rdq && (model.size() > 0);
      wr_ok = wr && ((model.size() < 64) || rd_ok);
      if (rd_ok) begin
        v = model.pop_front();
        if (tp) exp_tx.push_back(v);
        else    exp_host.push_back(v);
      end
      if (wr_ok) model.push_back(rp ? rd : hd);
      e_ovf = wr && !wr_ok;
      e_unf = rdq && !rd_ok;
    end
    @(posedge clk);
    #1;
    rx_push = 0; host_push = 0; tx_pop = 0; host_pop = 0; flush = 0;
    check("occupancy", 32'(occupancy), 32'(model.size()));
    check("empty", 32'(empty), 32'(model.size() == 0));
    check("full", 32'(full), 32'(model.size() == 64));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("underflow", 32'(underflow), 32'(e_unf));
    if (exp_tx.size() > 0) last_tx = exp_tx.pop_front();
    if (exp_host.size() > 0) last_host = exp_host.pop_front();
    check("tx_data", 32'(tx_data), 32'(last_tx));
    check("host_rdata", 32'(host_rdata), 32'(last_host));
  endtask

  initial begin
    n_rst = 0; flush = 0; rx_push = 1; rx_data = 8'hAA; host_push = 1; host_wdata = 8'h55;
    tx_pop = 0; host_pop = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_host_wait", 32'(host_wait), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    n_rst = 1; rx_push = 0; host_push = 0;
    cyc(0, 8'h00, 0, 8'h00, 0, 0, 0);

    // Fill with 0x00..0x3F, then drain through TX across the pointer wrap.
    for (int i = 0; i < 64; i++) cyc(1, 8'(i), 0, 8'h00, 0, 0, 0);
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 64; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    check("drain_last", 32'(tx_data), 32'h3F);
    check("drain_empty", 32'(empty), 32'd1);

    // Write contention, host retry, then read contention and host read path.
    cyc(1, 8'hA5, 1, 8'h5A, 0, 0, 0);
    cyc(0, 8'h00, 1, 8'h5A, 0, 0, 0);
    check("contend_occ", 32'(occupancy), 32'd2);
    cyc(0, 8'h00, 0, 8'h00, 0, 1, 0);
    check("host_read", 32'(host_rdata), 32'hA5);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 0);
    check("tx_wins_read", 32'(tx_data), 32'h5A);

    // Full boundary: drop, then simultaneous write+read at full.
    for (int i = 0; i < 64; i++) cyc(1, 8'(8'h80 + i), 0, 8'h00, 0, 0, 0);
    cyc(1, 8'hEE, 0, 8'h00, 0, 0, 0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    cyc(1, 8'h77, 0, 8'h00, 1, 0, 0);
    check("full_rw_occ", 32'(occupancy), 32'd64);
    for (int i = 0; i < 64; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    check("full_rw_last", 32'(tx_data), 32'h77);

    // Empty boundary: read dropped even with a same-cycle write.
    cyc(1, 8'h11, 0, 8'h00, 1, 0, 0);
    check("unf_pulse", 32'(underflow), 32'd1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    check("empty_rw_data", 32'(tx_data), 32'h11);

    // Flush mid-operation with traffic in the same cycle.
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h20 + i), 0, 8'h00, 0, 0, 0);
    cyc(1, 8'h99, 1, 8'h98, 1, 1, 1);
    check("flush_occ", 32'(occupancy), 32'd0);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
